// File: rtl/multichannel_delay_pkg.sv
// Shared defaults for the multichannel delay line: word width, buffer address width and
// channel count used as parameter defaults by the top level.
package multichannel_delay_pkg;

  localparam int unsigned DefDw  = 16;
  localparam int unsigned DefAw  = 8;
  localparam int unsigned DefNch = 4;

endpackage

// File: rtl/multichannel_delay_ram.sv
// One channel's circular sample store: single write port, single registered read port
// with read enable so the read register holds between strobes. No reset.
module delay_line_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multichannel_delay.sv
// Per-channel programmable delay line with a shared write pointer and fill counter.
// Outputs are muted to zero until enough history exists for each channel's delay.
module multichannel_delay
  import multichannel_delay_pkg::*;
#(
  parameter int unsigned DW  = DefDw,
  parameter int unsigned AW  = DefAw,
  parameter int unsigned NCH = DefNch
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_in,
  input  logic [NCH*DW-1:0] sig_in,
  input  logic [NCH*AW-1:0] delay,
  output logic              ce_out,
  output logic [NCH*DW-1:0] sig_out,
  output logic [NCH-1:0]    valid_out
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     fill_q, fill_d;
  logic              ce_out_q;
  logic [NCH-1:0]    valid_q, valid_d;
  logic [NCH-1:0]    sel_ram_q, sel_ram_d;
  logic [NCH*DW-1:0] hold_q, hold_d;
  logic [NCH*AW-1:0] raddr;
  logic [NCH*DW-1:0] ram_rdata;
  logic              ram_we;

  assign ram_we = ce_in & rst_n;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    valid_d   = valid_q;
    sel_ram_d = sel_ram_q;
    hold_d    = hold_q;
    raddr     = '0;
    for (int c = 0; c < NCH; c++) begin
      raddr[c*AW +: AW] = wr_ptr_q - delay[c*AW +: AW];
    end
    if (ce_in) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != '1) begin
        fill_d = fill_q + AW'(1);
      end
      for (int c = 0; c < NCH; c++) begin
        valid_d[c]   = (fill_q >= delay[c*AW +: AW]);
        // Zero delay bypasses the RAM; a non-zero delay is served by the registered read.
        sel_ram_d[c] = valid_d[c] && (delay[c*AW +: AW] != '0);
        hold_d[c*DW +: DW] = (valid_d[c] && (delay[c*AW +: AW] == '0)) ?
                             sig_in[c*DW +: DW] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      ce_out_q  <= 1'b0;
      valid_q   <= '0;
      sel_ram_q <= '0;
      hold_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      ce_out_q  <= ce_in;
      valid_q   <= valid_d;
      sel_ram_q <= sel_ram_d;
      hold_q    <= hold_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    delay_line_ram #(
      .DW(DW),
      .AW(AW)
    ) u_ram (
      .clk_i  (clk),
      .we_i   (ram_we),
      .waddr_i(wr_ptr_q),
      .wdata_i(sig_in[g*DW +: DW]),
      .re_i   (ram_we),
      .raddr_i(raddr[g*AW +: AW]),
      .rdata_o(ram_rdata[g*DW +: DW])
    );
  end

  // Every source of this mux is a register, so sig_out changes only on clock edges.
  always_comb begin
    sig_out = '0;
    for (int c = 0; c < NCH; c++) begin
      sig_out[c*DW +: DW] = sel_ram_q[c] ? ram_rdata[c*DW +: DW] : hold_q[c*DW +: DW];
    end
  end

  assign ce_out    = ce_out_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_multichannel_delay.sv
// Randomized bench for multichannel_delay: a history-queue reference model predicts every
// output; a second small instance (AW=4) exercises write-pointer wrap.
module tb_multichannel_delay;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 2 ** AW;

  logic              clk;
  logic              rst_n;
  logic              ce_in;
  logic [NCH*DW-1:0] sig_in;
  logic [NCH*AW-1:0] delay;
  logic              ce_out;
  logic [NCH*DW-1:0] sig_out;
  logic [NCH-1:0]    valid_out;

  logic              w_ce;
  logic [DW-1:0]     w_sig;
  logic [3:0]        w_dly;
  logic              w_ce_out;
  logic [DW-1:0]     w_sig_out;
  logic [0:0]        w_valid;

  multichannel_delay #(
    .DW (DW),
    .AW (AW),
    .NCH(NCH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce_in    (ce_in),
    .sig_in   (sig_in),
    .delay    (delay),
    .ce_out   (ce_out),
    .sig_out  (sig_out),
    .valid_out(valid_out)
  );

  multichannel_delay #(
    .DW (DW),
    .AW (4),
    .NCH(1)
  ) dut_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce_in    (w_ce),
    .sig_in   (w_sig),
    .delay    (w_dly),
    .ce_out   (w_ce_out),
    .sig_out  (w_sig_out),
    .valid_out(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: every accepted sample since reset, in order.
  logic [NCH*DW-1:0] hist[$];
  int                k;
  logic              exp_ce;
  logic [NCH*DW-1:0] exp_sig;
  logic [NCH-1:0]    exp_valid;
  int                wk;
  logic [DW-1:0]     w_exp_sig;
  logic              w_exp_valid;
  logic              w_exp_ce;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    int fill;
    int d;
    logic [NCH*DW-1:0] h;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      hist.delete();
      k = 0;
      exp_ce = 1'b0;
      exp_sig = '0;
      exp_valid = '0;
      wk = 0;
      w_exp_sig = '0;
      w_exp_valid = 1'b0;
      w_exp_ce = 1'b0;
    end else begin
      exp_ce = ce_in;
      if (ce_in) begin
        hist.push_back(sig_in);
        fill = (k > DEPTH - 1) ? DEPTH - 1 : k;
        for (int c = 0; c < NCH; c++) begin
          d = int'(delay[c*AW +: AW]);
          if (fill >= d) begin
            h = hist[k - d];
            exp_valid[c] = 1'b1;
            exp_sig[c*DW +: DW] = h[c*DW +: DW];
          end else begin
            exp_valid[c] = 1'b0;
            exp_sig[c*DW +: DW] = '0;
          end
        end
        k++;
      end
      w_exp_ce = w_ce;
      if (w_ce) begin
        // Wrap instance always runs a ramp with delay 15.
        w_exp_valid = (wk >= 15);
        w_exp_sig   = (wk >= 15) ? DW'(wk - 15) : '0;
        wk++;
      end
    end
    check("ce_out", 64'(ce_out), 64'(exp_ce));
    check("valid_out", 64'(valid_out), 64'(exp_valid));
    check("sig_out", 64'(sig_out), 64'(exp_sig));
    check("wrap_ce_out", 64'(w_ce_out), 64'(w_exp_ce));
    check("wrap_valid", 64'(w_valid), 64'(w_exp_valid));
    check("wrap_sig", 64'(w_sig_out), 64'(w_exp_sig));
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < NCH; c++) begin
      sig_in[c*DW +: DW] = DW'($urandom);
    end
  endtask

  int ramp;

  initial begin
    rst_n = 1'b0;
    ce_in = 1'b1;
    sig_in = '0;
    delay = '0;
    w_ce = 1'b0;
    w_sig = '0;
    w_dly = 4'd15;
    k = 0;
    wk = 0;
    exp_ce = 1'b0;
    exp_sig = '0;
    exp_valid = '0;
    w_exp_sig = '0;
    w_exp_valid = 1'b0;
    w_exp_ce = 1'b0;

    // Reset held with strobes active.
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    rst_n = 1'b1;

    // Fixed delays 0,1,5,255 with a ramp on every channel.
    delay = {8'd255, 8'd5, 8'd1, 8'd0};
    for (ramp = 0; ramp < 300; ramp++) begin
      sig_in = {NCH{DW'(ramp)}};
      tick();
    end

    // Mid-stream reset with delay 3; ramp keeps counting so stale data would be visible.
    delay = {NCH{8'd3}};
    rst_n = 1'b0;
    sig_in = {NCH{DW'(ramp)}};
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ramp++;
      sig_in = {NCH{DW'(ramp)}};
      tick();
    end

    // Delay change on channel 0: 10 -> 50 -> 200; others fixed random delays.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 1; c < NCH; c++) begin
      delay[c*AW +: AW] = AW'($urandom_range(0, 120));
    end
    for (int i = 0; i < 260; i++) begin
      delay[0 +: AW] = (i < 100) ? 8'd10 : (i < 130) ? 8'd50 : 8'd200;
      rand_inputs();
      tick();
    end

    // Gapped strobes: explicit 1,0,0,1 then random enables and delay changes.
    ce_in = 1'b1; rand_inputs(); tick();
    ce_in = 1'b0; rand_inputs(); tick();
    ce_in = 1'b0; rand_inputs(); tick();
    ce_in = 1'b1; rand_inputs(); tick();
    for (int i = 0; i < 500; i++) begin
      if (i % 25 == 0) begin
        for (int c = 0; c < NCH; c++) begin
          delay[c*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255))
                                                          : AW'($urandom_range(0, 12));
        end
      end
      ce_in = 1'($urandom_range(0, 1));
      rand_inputs();
      tick();
    end

    // Wrap instance: AW=4, delay 15, 40 ramp strobes.
    ce_in = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w_ce = 1'b1;
      w_sig = DW'(i);
      tick();
    end
    w_ce = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
